// File: rtl/byteblast8_pkg.sv
// byteblast8 shared definitions: opcode values, execute-stage FSM states and ALU op selects.
// The opcode always occupies the top OPC_BITS bits of the instruction word.
package byteblast8_pkg;

  localparam int OPC_BITS = 3;

  localparam logic [OPC_BITS-1:0] OP_NOP = 3'b000;
  localparam logic [OPC_BITS-1:0] OP_LD  = 3'b001;
  localparam logic [OPC_BITS-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_BITS-1:0] OP_SUB = 3'b011;
  localparam logic [OPC_BITS-1:0] OP_STR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_LOAD_OP,
    S_STORE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB
  } alu_op_t;

  function automatic alu_op_t alu_op_for(input logic [OPC_BITS-1:0] opc);
    alu_op_t op;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      default: op = ALU_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational pass/add/sub for the execute stage.
// carry is the bit above the result: carry-out for add, borrow for sub, 0 for pass.
module exec_alu
  import byteblast8_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  alu_op_t              op,
  output logic [DATA_BITS-1:0] result,
  output logic                 carry
);

  logic [DATA_BITS:0] w_sum;

  always_comb begin
    w_sum = {1'b0, b};
    case (op)
      ALU_ADD: w_sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: w_sum = {1'b0, a} - {1'b0, b};
      default: w_sum = {1'b0, b};
    endcase
    result = w_sum[DATA_BITS-1:0];
    carry  = w_sum[DATA_BITS];
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: byteblast8 execute stage; runs LD/ADD/STR against ram through an accumulator.
// Define EXEC_SUB_EN to make opcode 011 a SUB instead of an illegal opcode.
module exec_unit
  import byteblast8_pkg::*;
#(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_BITS-1:0]    instr,
  input  logic [DATA_BITS-1:0]    ram_data_in,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic                    ram_w_enable,
  output logic [DATA_BITS-1:0]    ram_data_out,
  output logic [DATA_BITS-1:0]    acc,
  output logic                    carry,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal
);

  state_t                  r_state, w_next;
  logic [OPC_BITS-1:0]     r_op, w_opc;
  logic [ADDRESS_BITS-1:0] r_addr, w_addr;
  logic [DATA_BITS-1:0]    r_acc, w_alu_res;
  logic                    r_carry, r_illegal;
  logic                    w_alu_carry, w_legal, w_needs_fetch, w_accept;
  alu_op_t                 w_alu_op;

  assign w_opc    = instr[DATA_BITS-1 -: OPC_BITS];
  assign w_addr   = instr[ADDRESS_BITS-1:0];
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_legal       = 1'b1;
    w_needs_fetch = 1'b0;
    case (w_opc)
      OP_NOP, OP_STR: w_needs_fetch = 1'b0;
      OP_LD, OP_ADD:  w_needs_fetch = 1'b1;
`ifdef EXEC_SUB_EN
      OP_SUB:         w_needs_fetch = 1'b1;
`endif
      default:        w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    ram_address  = '0;
    ram_w_enable = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (w_needs_fetch)       w_next = S_FETCH_OP;
          else if (w_opc == OP_STR) w_next = S_STORE;
          else                      w_next = S_DONE;
        end
      end
      S_FETCH_OP: begin
        ram_address = r_addr;
        w_next      = S_LOAD_OP;
      end
      S_LOAD_OP: begin
        ram_address = r_addr;
        w_next      = S_DONE;
      end
      S_STORE: begin
        ram_address  = r_addr;
        ram_w_enable = 1'b1;
        w_next       = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand is latched at accept so instr may change freely while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= OP_NOP;
      r_addr    <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= w_opc;
        r_addr <= w_addr;
        if (!w_legal) r_illegal <= 1'b1;
      end
      if (r_state == S_LOAD_OP) begin
        r_acc <= w_alu_res;
        if (r_op != OP_LD) r_carry <= w_alu_carry;
      end
    end
  end

  assign w_alu_op = alu_op_for(r_op);

  exec_alu #(.DATA_BITS(DATA_BITS)) u_alu (
    .a      (r_acc),
    .b      (ram_data_in),
    .op     (w_alu_op),
    .result (w_alu_res),
    .carry  (w_alu_carry)
  );

  assign acc          = r_acc;
  assign ram_data_out = r_acc;
  assign carry        = r_carry;
  assign illegal      = r_illegal;

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage of byteblast8. Sits downstream of ctrl, which decodes the instruction word read from ram.
- Takes the 8-bit instruction (3-bit opcode, 5-bit operand address) and performs LD/ADD/STR against ram through an accumulator.
- Drives its own ram address and write-enable, which feed the ram through the existing address mux and w-enable path.
- Reports completion back to fde with a one-cycle done pulse.

Parameters:
- ADDRESS_BITS, 5: width of the ram address and operand field.
- DATA_BITS, 8: width of the data, accumulator and instruction word. Must satisfy DATA_BITS >= ADDRESS_BITS+3.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to execute instr; sampled only in IDLE.
- instr  input  DATA_BITS  instruction word: opcode = instr[DATA_BITS-1:DATA_BITS-3], address = instr[ADDRESS_BITS-1:0].
- ram_data_in  input  DATA_BITS  ram read data, valid one clock after the address is presented.
- ram_address  output  ADDRESS_BITS  operand address to ram.
- ram_w_enable  output  1  ram write strobe.
- ram_data_out  output  DATA_BITS  ram write data; always equals acc.
- acc  output  DATA_BITS  accumulator.
- carry  output  1  carry/borrow from the last arithmetic operation.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- illegal  output  1  sticky flag for an unknown opcode.

Behaviour:
- Reset (async, reset=0): state=IDLE; acc, carry, done, illegal, ram_w_enable, ram_address all 0.
- Opcodes: 000 NOP, 001 LD, 010 ADD, 100 STR. Every other opcode is illegal.
- FSM states: IDLE, FETCH_OP, LOAD_OP, STORE, DONE.
- IDLE: on start=1, latch opcode and address into instr_q, then branch:
  - LD or ADD -> FETCH_OP.
  - STR -> STORE.
  - NOP -> DONE.
  - Illegal -> DONE, and set illegal=1.
- FETCH_OP: ram_address=addr_q. Next state LOAD_OP.
- LOAD_OP: ram_address=addr_q; ram_data_in is valid.
  - LD: acc<=ram_data_in; carry unchanged.
  - ADD: {carry,acc}<=acc+ram_data_in (DATA_BITS+1-bit sum, wraps modulo 2^DATA_BITS).
  - Next state DONE.
- STORE: ram_address=addr_q, ram_w_enable=1 for exactly this cycle, ram_data_out=acc. Next state DONE.
- DONE: done=1 for one cycle. Next state IDLE.
- Latency, with start sampled at edge k:
  - LD/ADD: done high in cycle k+3.
  - STR: done high in cycle k+2.
  - NOP/illegal: done high in cycle k+1.
- back-to-back: start may be asserted in the DONE cycle, but is only sampled in IDLE. Minimum issue interval is therefore done+1.
- start while busy: ignored. instr changes while busy: ignored, because instr_q holds the latched value.
- ram_address is 0 in IDLE and DONE.
- illegal clears only on reset. It does not block further instructions.
- Reset mid-operation: immediate return to IDLE with the reset values above. A STORE interrupted by reset before the clock edge performs no write.

Optional Feature:
- Macro: EXEC_SUB_EN.
- Defined: opcode 011 = SUB, following the LD/ADD path (FETCH_OP, LOAD_OP). Result {carry,acc}<=acc-ram_data_in; carry=1 signals a borrow (ram_data_in > acc). Latency is the same as ADD.
- Not defined: 011 is illegal.

Decomposition:
- Package byteblast8_pkg:
  - Opcode constants OP_NOP, OP_LD, OP_ADD, OP_STR, OP_SUB.
  - FSM state encoding.
  - Opcode field position.
- Sub-module exec_alu, purely combinational: inputs a, b and op (add/sub/pass); outputs result and carry. This isolates the arithmetic used in LOAD_OP.

Test Plan:
- Reset: hold reset=0 with start=1 and instr=8'h23 -> acc=0, carry=0, busy=0, done=0, ram_w_enable=0; no state change.
- LD: ram[3]=2, pulse start with instr=8'h23 -> ram_address=3 in cycles k+1 and k+2; acc=2 and done=1 in cycle k+3; busy drops in cycle k+4.
- ADD plus ignored start: after the LD, ram[4]=5, instr=8'h44 -> acc=7, carry=0. A second start pulse in cycle k+1 is ignored.
- STR: instr=8'h85 with acc=7 -> ram_w_enable=1 for one cycle with ram_address=5 and ram_data_out=7; afterwards ram[5]=7; done in cycle k+2.
- Overflow and mid-op reset:
  - acc=8'hF0, ram[3]=8'h20, ADD -> acc=8'h10, carry=1.
  - Repeat the ADD and assert reset during LOAD_OP -> acc=0, state IDLE, no done pulse.
- Illegal/SUB: instr=8'hE0 -> illegal=1, done in cycle k+1. instr=8'h63 with acc=1, ram[3]=2 gives:
  - With EXEC_SUB_EN: acc=8'hFF, carry=1.
  - Without: illegal=1 and acc unchanged.
